// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel bus-mapped PWM peripheral.
// Each channel has a double-buffered period/duty pair (shadow -> active at wrap),
// an enable, an output polarity and a sticky wrap flag that can raise irq.
//
// Bus handshake (valid/ready): the master raises valid in cycle T and holds it,
// together with addr/wstrb/wdata, until it sees ready. The block answers with a
// single-cycle ready in T+1; rdata carries the read value in that cycle only and
// is 0 otherwise. A write commits on the clock edge that ends T+1. ready is never
// asserted twice for one request, so a new request may start in T+2.
module pwm_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  output logic                ready,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  // Bus response registers
  logic                r_ready;
  logic [31:0]         r_rdata;

  // Configuration and status registers
  logic [CHANNELS-1:0] r_en;
  logic [CHANNELS-1:0] r_pol;
  logic [CHANNELS-1:0] r_status;
  logic [CHANNELS-1:0] r_irq_en;
  logic [WIDTH-1:0]    r_per_sh  [CHANNELS];
  logic [WIDTH-1:0]    r_duty_sh [CHANNELS];

  // Per-channel datapath
  logic [WIDTH-1:0]    r_per     [CHANNELS];
  logic [WIDTH-1:0]    r_duty    [CHANNELS];
  logic [WIDTH-1:0]    r_cnt     [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;

  // Decode / merge wires
  logic [5:0]          w_word;
  logic                w_wr;
  logic                w_wr_ctrl;
  logic                w_wr_status;
  logic                w_wr_irq_en;
  logic [CHANNELS-1:0] w_wr_per;
  logic [CHANNELS-1:0] w_wr_duty;
  logic [31:0]         w_rd;
  logic [31:0]         w_bmask;
  logic [31:0]         w_merged;
  logic [31:0]         w_clr;
  logic [CHANNELS-1:0] w_en_nxt;
  logic [CHANNELS-1:0] w_wrap;
  logic                w_unused;

  assign w_word      = addr[7:2];
  // Writes commit in the ready cycle, while the master still holds valid.
  assign w_wr        = valid & r_ready & (wstrb != 4'b0000);
  assign w_wr_ctrl   = w_wr & (w_word == 6'd0);
  assign w_wr_status = w_wr & (w_word == 6'd1);
  assign w_wr_irq_en = w_wr & (w_word == 6'd2);

  assign w_bmask  = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  // Byte-lane merge of write data over the current register contents.
  assign w_merged = (wdata & w_bmask) | (w_rd & ~w_bmask);
  // STATUS is write-1-to-clear, only on enabled byte lanes.
  assign w_clr    = wdata & w_bmask;

  assign w_en_nxt = w_wr_ctrl ? w_merged[CHANNELS-1:0] : r_en;

  // Address decode and read mux; unmapped offsets read 0.
  always_comb begin
    w_rd      = 32'd0;
    w_wr_per  = '0;
    w_wr_duty = '0;
    case (w_word)
      6'd0:    w_rd = 32'(r_en) | (32'(r_pol) << 16);
      6'd1:    w_rd = 32'(r_status);
      6'd2:    w_rd = 32'(r_irq_en);
      default: w_rd = 32'd0;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (w_word == 6'(4 + 2 * n)) begin
        w_rd        = 32'(r_per_sh[n]);
        w_wr_per[n] = w_wr;
      end
      if (w_word == 6'(5 + 2 * n)) begin
        w_rd         = 32'(r_duty_sh[n]);
        w_wr_duty[n] = w_wr;
      end
    end
  end

  // Wrap happens on the last count of an enabled channel's period.
  always_comb begin
    w_wrap = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      w_wrap[n] = r_en[n] && (r_cnt[n] == r_per[n]);
    end
  end

  // Bus response: one ready pulse per request, rdata only alongside ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= valid & ~r_ready;
      r_rdata <= (valid & ~r_ready) ? w_rd : 32'd0;
    end
  end

  // Software-visible configuration registers and shadow period/duty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en     <= '0;
      r_pol    <= '0;
      r_irq_en <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        r_per_sh[n]  <= '0;
        r_duty_sh[n] <= '0;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en  <= w_merged[CHANNELS-1:0];
        r_pol <= w_merged[16 +: CHANNELS];
      end
      if (w_wr_irq_en) begin
        r_irq_en <= w_merged[CHANNELS-1:0];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (w_wr_per[n])  r_per_sh[n]  <= w_merged[WIDTH-1:0];
        if (w_wr_duty[n]) r_duty_sh[n] <= w_merged[WIDTH-1:0];
      end
    end
  end

  // Sticky wrap flags; a wrap on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~(w_wr_status ? w_clr[CHANNELS-1:0] : '0)) | w_wrap;
    end
  end

  // Counters and active period/duty; shadows load on enable rise and at wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_cnt[n]  <= '0;
        r_per[n]  <= '0;
        r_duty[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (!w_en_nxt[n]) begin
          r_cnt[n] <= '0;
        end else if (!r_en[n] || w_wrap[n]) begin
          r_cnt[n]  <= '0;
          r_per[n]  <= r_per_sh[n];
          r_duty[n] <= r_duty_sh[n];
        end else begin
          r_cnt[n] <= r_cnt[n] + WIDTH'(1);
        end
      end
    end
  end

  // Registered PWM outputs; disabled channels sit at their polarity level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        r_pwm[n] <= r_en[n] ? ((r_cnt[n] < r_duty[n]) ^ r_pol[n]) : r_pol[n];
      end
    end
  end

  assign ready    = r_ready;
  assign rdata    = r_rdata;
  assign pwm_out  = r_pwm;
  assign irq      = |(r_status & r_irq_en);
  assign w_unused = ^{addr[31:8], addr[1:0], w_merged, w_clr};

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: reset/idle, basic PWM, double buffering,
// edge duties with polarity, interrupts, bus corner cases and async reset.
module tb_pwm_multi;

  localparam int CH = 4;

  logic          clk;
  logic          resetn;
  logic          valid;
  logic          ready;
  logic [3:0]    wstrb;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic [CH-1:0] pwm_out;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;
  int ready_cnt = 0;

  // Run lengths of pwm_out[0] and the expected high runs
  int          hi_q[$];
  int          lo_q[$];
  logic [31:0] exp_q[$];
  logic        m_prev = 1'b0;
  int          m_len  = 0;

  pwm_multi #(.CHANNELS(CH), .WIDTH(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid   (valid),
    .ready   (ready),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .pwm_out (pwm_out),
    .irq     (irq)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready pulse counter and pwm_out[0] run-length monitor
  always @(negedge clk) begin
    if (ready) ready_cnt++;
    if (!resetn) begin
      m_prev = 1'b0;
      m_len  = 0;
    end else if (pwm_out[0] == m_prev) begin
      m_len++;
    end else begin
      if (m_prev) hi_q.push_back(m_len);
      else        lo_q.push_back(m_len);
      m_len  = 1;
      m_prev = pwm_out[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ready) got = 1'b1;
    end
    if (!got) check("wr_ready_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bit got;
    got = 1'b0;
    d   = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    valid = 1'b1; addr = a; wdata = 32'd0; wstrb = 4'd0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ready) begin
        got = 1'b1;
        d   = rdata;
      end
    end
    if (!got) check("rd_ready_timeout", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic count_ones0(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm_out[0]) c++;
    end
  endtask

  task automatic wait_rise0();
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = pwm_out[0];
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pwm_out[0] && !prev) ok = 1'b1;
      prev = pwm_out[0];
    end
    if (!ok) check("rise_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  logic [31:0] rd;
  int          c;
  int          rc;
  logic [31:0] idle_addrs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};

  initial begin
    resetn = 1'b0; valid = 1'b0; wstrb = 4'd0; addr = 32'd0; wdata = 32'd0;

    // ---------------- reset / idle ----------------
    cycles(3);
    @(negedge clk);
    check("rst_pwm",   32'(pwm_out), 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    cycles(5);
    @(negedge clk);
    check("idle_no_ready", 32'(ready_cnt), 32'd0);
    check("idle_pwm", 32'(pwm_out), 32'd0);
    foreach (idle_addrs[i]) begin
      bus_read(idle_addrs[i], rd);
      check("idle_reg_zero", rd, 32'd0);
    end

    // ---------------- basic PWM ----------------
    bus_write(32'h10, 32'd9, 4'hF);
    bus_write(32'h14, 32'd3, 4'hF);
    bus_write(32'h00, 32'd1, 4'hF);
    bus_read(32'h04, rd);
    check("status_before_wrap", rd, 32'd0);
    cycles(15);
    bus_read(32'h04, rd);
    check("status_after_wrap", rd, 32'd1);
    hi_q.delete(); lo_q.delete();
    cycles(30);
    check("basic_hi_runs", 32'(hi_q.size() >= 2), 32'd1);
    check("basic_lo_runs", 32'(lo_q.size() >= 2), 32'd1);
    foreach (hi_q[i]) check("basic_hi_len", 32'(hi_q[i]), 32'd3);
    foreach (lo_q[i]) check("basic_lo_len", 32'(lo_q[i]), 32'd7);
    // W1C aligned well away from the next wrap
    wait_rise0();
    bus_write(32'h04, 32'd1, 4'hF);
    bus_read(32'h04, rd);
    check("status_w1c", rd, 32'd0);

    // ---------------- double buffer ----------------
    wait_rise0();
    hi_q.delete();
    bus_write(32'h14, 32'd7, 4'hF);
    cycles(25);
    exp_q.delete();
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd7);
    foreach (exp_q[i]) check("db_mid_write", 32'(hi_q[i]), exp_q[i]);
    // Write committing exactly on the wrap edge applies one period later
    wait_rise0();
    hi_q.delete();
    cycles(6);
    bus_write(32'h14, 32'd2, 4'hF);
    cycles(30);
    exp_q.delete();
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd2);
    foreach (exp_q[i]) check("db_wrap_write", 32'(hi_q[i]), exp_q[i]);

    // ---------------- edge duties / polarity ----------------
    bus_write(32'h14, 32'd0, 4'hF);
    cycles(25);
    count_ones0(10, c);
    check("duty0_const_low", 32'(c), 32'd0);
    bus_write(32'h14, 32'd12, 4'hF);
    cycles(25);
    count_ones0(10, c);
    check("duty_gt_per_const_high", 32'(c), 32'd10);
    bus_write(32'h00, 32'h0001_0001, 4'hF);
    cycles(3);
    count_ones0(10, c);
    check("pol_duty_gt_per_low", 32'(c), 32'd0);
    bus_write(32'h14, 32'd0, 4'hF);
    cycles(25);
    count_ones0(10, c);
    check("pol_duty0_high", 32'(c), 32'd10);
    // PERIOD=0: every cycle wraps, so a W1C cannot clear the flag
    bus_write(32'h10, 32'd0, 4'hF);
    cycles(25);
    bus_write(32'h04, 32'd1, 4'hF);
    bus_read(32'h04, rd);
    check("per0_status_every_cycle", rd, 32'd1);
    // Disable: output back to (now cleared) polarity level one cycle later
    bus_write(32'h00, 32'd0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("disable_to_pol", {31'd0, pwm_out[0]}, 32'd0);

    // ---------------- interrupt / bus ----------------
    bus_write(32'h04, 32'hF, 4'hF);
    bus_write(32'h10, 32'd9, 4'hF);
    bus_write(32'h14, 32'd3, 4'hF);
    bus_write(32'h08, 32'd2, 4'hF);
    bus_write(32'h00, 32'd1, 4'hF);
    c = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (irq) c++;
    end
    check("ch0_wrap_no_irq", 32'(c), 32'd0);
    bus_read(32'h04, rd);
    check("ch0_status_set", rd, 32'd1);
    bus_write(32'h18, 32'd4, 4'hF);
    bus_write(32'h1C, 32'd2, 4'hF);
    bus_write(32'h00, 32'd3, 4'hF);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq) c++;
    end
    check("irq_low_before_ch1_wrap", 32'(c), 32'd0);
    @(negedge clk);
    check("irq_after_ch1_wrap", {31'd0, irq}, 32'd1);
    bus_write(32'h04, 32'd2, 4'hF);
    @(negedge clk);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rc = ready_cnt;
    bus_read(32'hFC, rd);
    cycles(3);
    @(negedge clk);
    check("unmapped_read_zero", rd, 32'd0);
    check("unmapped_single_ready", 32'(ready_cnt - rc), 32'd1);
    bus_write(32'h10, 32'hABCD_1234, 4'hF);
    bus_read(32'h10, rd);
    check("period_upper_zero", rd, 32'h0000_1234);
    bus_write(32'h10, 32'hFFFF_FF56, 4'b0001);
    bus_read(32'h10, rd);
    check("period_byte0_write", rd, 32'h0000_1256);

    // ---------------- async reset mid-run ----------------
    bus_write(32'h00, 32'h0004_0003, 4'hF);
    cycles(3);
    @(negedge clk);
    check("pre_reset_pol_ch2", {31'd0, pwm_out[2]}, 32'd1);
    @(posedge clk); #1;
    valid = 1'b1; addr = 32'h0; wstrb = 4'd0;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    rc = ready_cnt;
    cycles(3);
    valid = 1'b0;
    @(negedge clk);
    check("async_rst_no_ready", 32'(ready_cnt - rc), 32'd0);
    resetn = 1'b1;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_out != '0) c++;
    end
    check("post_reset_disabled", 32'(c), 32'd0);
    bus_read(32'h00, rd);
    check("post_reset_ctrl", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, bus-mapped PWM peripheral for the picorv32 SoC, replacing the fixed single-channel PWM. It provides CHANNELS independent channels, each with its own period and duty, and a per-channel output polarity. Period and duty writes are double-buffered and take effect at the next period boundary. Per-channel period-wrap status drives a level interrupt into the CPU `irq` vector. It sits on the shared `mem_*` bus; address decode and `valid` qualification are done in the top level.

## Interface
- CHANNELS, 4, number of channels, 1..16
- WIDTH, 16, counter/period/duty width, 2..32
- clk  input  1  system clock
- resetn  input  1  reset; one clock; reset is asynchronous and active-low
- valid  input  1  bus request, already qualified by the top-level address select
- ready  output  1  single-cycle completion pulse
- wstrb  input  4  byte write strobes; 0 = read
- addr  input  32  byte address; only addr[7:2] decoded
- wdata  input  32  write data
- rdata  output  32  read data, valid while ready=1
- pwm_out  output  CHANNELS  registered PWM outputs
- irq  output  1  level interrupt = |(STATUS & IRQ_EN)

## Operation
- Register map (addr[7:0]):
  - 0x00 CTRL: [CHANNELS-1:0] enable, [16+CHANNELS-1:16] polarity invert.
  - 0x04 STATUS: [CHANNELS-1:0] wrap flags, write-1-to-clear.
  - 0x08 IRQ_EN: [CHANNELS-1:0].
  - 0x10+8n PERIOD_n shadow; 0x14+8n DUTY_n shadow; both [WIDTH-1:0], upper bits read 0.
- Unmapped offsets: reads return 0, writes ignored, ready still pulses.
- Byte writes honour wstrb per byte lane.
- Reads of PERIOD/DUTY return the shadow value, not the active value.
- Per channel: active period P, active duty D, counter cnt.
- Enabled channel: cnt counts 0..P, then wraps to 0, so the period is P+1 cycles.
- At wrap (cnt==P): load P and D from shadow, set STATUS[n].
- If a set and a W1C of the same flag coincide, the set wins.
- Enable 0->1: cnt=0, active registers loaded from shadow. STATUS is not set.
- Disabled channel: cnt held at 0.
- Output: pwm_out[n] <= en ? ((cnt < D) ^ pol) : pol.
- D=0: output is constantly inactive.
- D>P: output is constantly active (100%).
- P=0: every cycle is a wrap and STATUS is set every cycle.
- Comparison is unsigned, WIDTH bits. The counter never exceeds P, even if P shrinks: the new P is loaded only at wrap.

## Timing
- Reset values: all registers 0, cnt 0, pwm_out 0, ready 0, rdata 0, irq 0.
- Bus handshake:
  - valid rises in cycle T; ready=1 in T+1 for exactly one cycle. rdata is valid in T+1 and 0 otherwise.
  - The write commits on the clock edge ending T+1.
  - valid is held by the master until ready. A new request may start in T+2.
  - The block never asserts ready twice for one request.
- Write vs. wrap on the same edge: the wrap loads the pre-write shadow value; the new shadow applies at the following wrap.
- pwm_out lags cnt by 1 cycle (registered).
- irq is combinational from registered STATUS/IRQ_EN, so it rises 1 cycle after the wrap edge.
- CTRL enable clear takes effect on the next edge: cnt=0 and the output returns to the pol level one cycle later.
- resetn asserted mid-operation clears everything asynchronously; an in-flight bus request gets no ready.

## Test plan
- Reset/idle: hold resetn=0, then release with no access.
  - Required: pwm_out=0, irq=0, ready never pulses, all registers read 0.
- Basic PWM: ch0 PERIOD=9, DUTY=3, enable.
  - Required: pwm_out[0] repeats 3 cycles high, 7 low.
  - Required: STATUS[0]=1 after the first wrap.
  - Required: writing 1 to STATUS clears it.
- Double-buffer: mid-period write DUTY_0=7.
  - Required: the current period stays 3 high.
  - Required: the next period is 7 high.
  - Required: a write coinciding with the wrap applies one period later.
- Edge duties: DUTY=0 gives constant 0; DUTY=12 with PERIOD=9 gives constant 1.
  - Required: with polarity bit 16 set, both are inverted.
  - Required: with PERIOD=0, STATUS[0] is set every cycle.
- Interrupt/bus: IRQ_EN=0x2, ch1 PERIOD=4.
  - Required: irq rises 1 cycle after the ch1 wrap and falls after W1C.
  - Required: ch0 wraps do not raise irq.
  - Required: a read of 0xFC returns 0 with a single ready pulse.
  - Required: a wstrb=0001 write to PERIOD_0 changes byte 0 only.
- Async reset mid-run: assert resetn during active PWM with a pending bus request.
  - Required: immediate pwm_out=0 and no ready.
  - Required: after release, channels stay disabled.
